bnn_sequencer: RTL and testbench

BNN_SEQUENCER -- requirements
Module: bnn_sequencer

---
 rtl/bnn_pkg.sv | 22 ++
 rtl/pixel_loader.sv | 38 +++
 rtl/bnn_sequencer.sv | 119 +++++++++++
 tb/tb_bnn_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN sequencer and the layer blocks it drives:
// phase encodings, image geometry and the default transfer count.
package bnn_pkg;

  localparam int IMG_W      = 28;
  localparam int IMG_BITS   = 784;
  localparam int LOAD_BYTES = 98;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_LOAD    = 3'b001,
    ST_LAYER_1 = 3'b010,
    ST_LAYER_2 = 3'b011,
    ST_LAYER_3 = 3'b100,
    ST_DONE    = 3'b101
  } state_t;

  function automatic logic is_layer(input state_t s);
    return (s == ST_LAYER_1) || (s == ST_LAYER_2) || (s == ST_LAYER_3);
  endfunction

endpackage

// File: rtl/pixel_loader.sv
// Byte counter plus image register: byte k lands in pixels[8k+7:8k] on the edge it is accepted.
// load_done is combinational and marks the cycle in which the final byte is accepted.
module pixel_loader #(
  parameter int LOAD_BYTES = bnn_pkg::LOAD_BYTES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic                         pix_valid,
  input  logic [7:0]                   pix_data,
  output logic [bnn_pkg::IMG_BITS-1:0] pixels,
  output logic                         load_done
);
  import bnn_pkg::*;

  localparam int              CNT_W = $clog2(LOAD_BYTES + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(LOAD_BYTES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LOAD_BYTES - 1);

  logic [CNT_W-1:0] cnt;
  logic             xfer;

  // The FULL guard keeps the counter from wrapping even if en were held past the last byte.
  assign xfer      = en && pix_valid && (cnt != FULL);
  assign load_done = xfer && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt    <= '0;
      pixels <= '0;
    end else if (xfer) begin
      pixels[{cnt, 3'b000} +: 8] <= pix_data;
      cnt                        <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bnn_sequencer.sv
// Top-level phase controller: IDLE -> LOAD -> LAYER_1..3 -> DONE, with per-layer timeout abort.
// Every transition lands one edge after its trigger; pixel intake is valid/ready, layers are level-done.
module bnn_sequencer #(
  parameter int          LOAD_BYTES = bnn_pkg::LOAD_BYTES,
  parameter logic [15:0] TIMEOUT    = 16'hFFFF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         pix_valid,
  input  logic [7:0]                   pix_data,
  output logic                         pix_ready,
  output logic [2:0]                   state,
  output logic [bnn_pkg::IMG_BITS-1:0] pixels,
  output logic                         layer_clr,
  input  logic                         l1_done,
  input  logic                         l2_done,
  input  logic                         l3_done,
  input  logic [3:0]                   digit_in,
  output logic [3:0]                   digit,
  output logic                         digit_valid,
  output logic                         busy,
  output logic                         err
);
  import bnn_pkg::*;

  state_t      cur_state;
  state_t      nxt_state;
  logic [15:0] cyc;
  logic        accept_start;
  logic        layer_done;
  logic        timeout_hit;
  logic        load_done;

  assign accept_start = start && ((cur_state == ST_IDLE) || (cur_state == ST_DONE));
  assign state        = cur_state;

  // Only the flag belonging to the current layer is looked at.
  always_comb begin
    layer_done = 1'b0;
    case (cur_state)
      ST_LAYER_1: layer_done = l1_done;
      ST_LAYER_2: layer_done = l2_done;
      ST_LAYER_3: layer_done = l3_done;
      default:    layer_done = 1'b0;
    endcase
  end

  // cyc counts cycles already spent in this state, so TIMEOUT-1 means the state has lasted TIMEOUT cycles.
  assign timeout_hit = is_layer(cur_state) && !layer_done && (cyc == TIMEOUT - 16'd1);

  pixel_loader #(
    .LOAD_BYTES(LOAD_BYTES)
  ) u_loader (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept_start),
    .en        (pix_ready),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pixels    (pixels),
    .load_done (load_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      ST_IDLE:    if (accept_start) nxt_state = ST_LOAD;
      ST_LOAD:    if (load_done)    nxt_state = ST_LAYER_1;
      ST_LAYER_1: if (layer_done)   nxt_state = ST_LAYER_2;
                  else if (timeout_hit) nxt_state = ST_IDLE;
      ST_LAYER_2: if (layer_done)   nxt_state = ST_LAYER_3;
                  else if (timeout_hit) nxt_state = ST_IDLE;
      ST_LAYER_3: if (layer_done)   nxt_state = ST_DONE;
                  else if (timeout_hit) nxt_state = ST_IDLE;
      ST_DONE:    if (accept_start) nxt_state = ST_LOAD;
      default:    nxt_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (cur_state == ST_LOAD) || is_layer(cur_state);
    pix_ready   = (cur_state == ST_LOAD) && !layer_clr;
    digit_valid = (cur_state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc       <= '0;
      layer_clr <= 1'b0;
      err       <= 1'b0;
      digit     <= '0;
    end else begin
      layer_clr <= accept_start;
      if (nxt_state != cur_state) begin
        cyc <= '0;
      end else if (cyc != 16'hFFFF) begin
        cyc <= cyc + 16'd1;
      end
      if (accept_start) begin
        err <= 1'b0;
      end else if (timeout_hit) begin
        err <= 1'b1;
      end
      if ((cur_state == ST_LAYER_3) && l3_done) begin
        digit <= digit_in;
      end
    end
  end

endmodule

// File: tb/tb_bnn_sequencer.sv
// Directed bench for bnn_sequencer: nominal run, stalled load, ignored inputs, timeout, re-run and reset.
module tb_bnn_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         pix_valid;
  logic [7:0]   pix_data;
  logic         pix_ready;
  logic [2:0]   state;
  logic [783:0] pixels;
  logic         layer_clr;
  logic         l1_done;
  logic         l2_done;
  logic         l3_done;
  logic [3:0]   digit_in;
  logic [3:0]   digit;
  logic         digit_valid;
  logic         busy;
  logic         err;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           k;
  logic [783:0] exp_pix;

  bnn_sequencer #(
    .LOAD_BYTES(98),
    .TIMEOUT   (16'd20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_ready   (pix_ready),
    .state       (state),
    .pixels      (pixels),
    .layer_clr   (layer_clr),
    .l1_done     (l1_done),
    .l2_done     (l2_done),
    .l3_done     (l3_done),
    .digit_in    (digit_in),
    .digit       (digit),
    .digit_valid (digit_valid),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [783:0] obs, input logic [783:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] byte_of(input int idx);
    return 8'(idx * 3) ^ 8'h5A;
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = 8'h00;
    l1_done = 1'b0; l2_done = 1'b0; l3_done = 1'b0; digit_in = 4'd0;
    repeat (2) tick();
    chk("rst_state", state, 3'd0);
    chk("rst_pixels", pixels, '0);
    chk("rst_digit", digit, 4'd0);
    chk("rst_digit_valid", digit_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_layer_clr", layer_clr, 1'b0);
    chk("rst_pix_ready", pix_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();

    // Nominal run: 98 x 0xA5, each layer done 10 cycles after entry, digit 7.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("nom_load_entry", state, 3'd1);
    chk("nom_layer_clr", layer_clr, 1'b1);
    chk("nom_ready_in_clr", pix_ready, 1'b0);
    chk("nom_busy", busy, 1'b1);
    pix_valid = 1'b1; pix_data = 8'hA5;
    tick();
    chk("nom_layer_clr_end", layer_clr, 1'b0);
    chk("nom_ready", pix_ready, 1'b1);
    chk("nom_no_xfer_in_clr", pixels, '0);
    repeat (97) tick();
    chk("nom_still_load", state, 3'd1);
    tick();
    pix_valid = 1'b0;
    exp_pix = {98{8'hA5}};
    chk("nom_l1_entry", state, 3'd2);
    chk("nom_pixels", pixels, exp_pix);
    chk("nom_ready_l1", pix_ready, 1'b0);
    repeat (9) tick();
    chk("nom_l1_hold", state, 3'd2);
    l1_done = 1'b1;
    tick();
    chk("nom_l2_entry", state, 3'd3);
    repeat (9) tick();
    chk("nom_l2_hold", state, 3'd3);
    l2_done = 1'b1;
    tick();
    chk("nom_l3_entry", state, 3'd4);
    chk("nom_dv_before", digit_valid, 1'b0);
    repeat (9) tick();
    chk("nom_l3_hold", state, 3'd4);
    digit_in = 4'd7; l3_done = 1'b1;
    tick();
    chk("nom_done", state, 3'd5);
    chk("nom_digit", digit, 4'd7);
    chk("nom_digit_valid", digit_valid, 1'b1);
    chk("nom_busy_done", busy, 1'b0);
    chk("nom_pixels_hold", pixels, exp_pix);
    digit_in = 4'd3;
    tick();
    chk("nom_digit_hold", digit, 4'd7);

    // Re-run from DONE, stalled load with a stray start at byte 50.
    start = 1'b1;
    tick();
    start = 1'b0;
    l1_done = 1'b0; l2_done = 1'b0; l3_done = 1'b0;
    chk("rerun_layer_clr", layer_clr, 1'b1);
    chk("rerun_dv_drop", digit_valid, 1'b0);
    chk("rerun_pix_clear", pixels, '0);
    chk("rerun_state", state, 3'd1);
    tick();
    exp_pix = '0;
    k = 0;
    for (int i = 0; i < 400 && k < 98; i++) begin
      pix_valid = (i % 2 == 0);
      pix_data  = pix_valid ? byte_of(k) : 8'hEE;
      start     = pix_valid && (k == 50);
      if (pix_valid) begin
        exp_pix[8*k +: 8] = byte_of(k);
        k++;
      end
      tick();
      start = 1'b0;
      if (k < 98) chk("stall_in_load", state, 3'd1);
    end
    chk("stall_l1_entry", state, 3'd2);
    chk("stall_pixels", pixels, exp_pix);
    pix_valid = 1'b1; pix_data = 8'hFF;
    tick();
    pix_valid = 1'b0;
    chk("stall_no_extra", pixels, exp_pix);

    // Foreign done flag in LAYER_1 is ignored.
    l3_done = 1'b1;
    repeat (5) tick();
    chk("ign_l3_in_l1", state, 3'd2);
    chk("ign_digit", digit, 4'd7);
    l3_done = 1'b0; l1_done = 1'b1;
    tick();
    chk("to_l2_entry", state, 3'd3);

    // l2_done never comes: abort after exactly 20 cycles in LAYER_2.
    repeat (19) tick();
    chk("to_l2_cycle20", state, 3'd3);
    chk("to_err_low", err, 1'b0);
    tick();
    chk("to_state_idle", state, 3'd0);
    chk("to_err_set", err, 1'b1);
    chk("to_busy", busy, 1'b0);
    chk("to_pixels_hold", pixels, exp_pix);
    l1_done = 1'b0;
    tick();
    chk("to_err_sticky", err, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("to_err_clr", err, 1'b0);
    chk("to_layer_clr", layer_clr, 1'b1);
    chk("to_load", state, 3'd1);
    chk("to_pix_clear", pixels, '0);
    tick();
    chk("to_layer_clr_end", layer_clr, 1'b0);

    // Reset in LAYER_2 with a coincident start and done.
    pix_valid = 1'b1; pix_data = 8'h0F;
    repeat (98) tick();
    pix_valid = 1'b0;
    chk("rst_run_l1", state, 3'd2);
    chk("rst_run_pixels", pixels, {98{8'h0F}});
    l1_done = 1'b1;
    tick();
    chk("rst_run_l2", state, 3'd3);
    repeat (3) tick();
    rst = 1'b1; start = 1'b1; l2_done = 1'b1;
    tick();
    chk("mid_rst_state", state, 3'd0);
    chk("mid_rst_pixels", pixels, '0);
    chk("mid_rst_digit", digit, 4'd0);
    chk("mid_rst_dv", digit_valid, 1'b0);
    chk("mid_rst_err", err, 1'b0);
    chk("mid_rst_layer_clr", layer_clr, 1'b0);
    chk("mid_rst_ready", pix_ready, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    rst = 1'b0; start = 1'b0; l1_done = 1'b0; l2_done = 1'b0;
    tick();
    chk("post_rst_idle", state, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
